// File: rtl/apb_uart_periph_if.sv
// APB bus bundle between the APB master and the UART peripheral window.
interface apb_uart_periph_if;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PWRITE, PENABLE, PWDATA, PSEL,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWRITE, PENABLE, PWDATA, PSEL,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_uart_periph.sv
// APB UART peripheral: TX FIFO feeding the UART TX core, RX FIFO for received bytes,
// registered PRDATA/PREADY with one wait state per transfer.
module apb_uart_periph #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_uart_periph_if.slave  apb,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  input  logic              tx_done,
  input  logic [7:0]        rx_data,
  input  logic              rx_done
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] A_USR = 2'd0;
  localparam logic [1:0] A_UWD = 2'd1;
  localparam logic [1:0] A_URD = 2'd2;
  localparam logic [1:0] A_UCR = 2'd3;

  typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT} tx_state_t;

  tx_state_t       tx_state;
  logic [7:0]      tx_mem [FIFO_DEPTH];
  logic [7:0]      rx_mem [FIFO_DEPTH];
  logic [PW-1:0]   tx_wp, tx_rp, rx_wp, rx_rp;
  logic            rx_overrun;

  logic            access;
  logic [1:0]      reg_sel;
  logic            tx_empty, tx_full, rx_empty, rx_full;
  logic            tx_idle;
  logic            tx_pop, tx_push;
  logic            rx_pop, rx_push, rx_drop;
  logic            ov_clear;
  logic [31:0]     usr;
  logic [31:0]     rd_val;
  logic            unused_bits;

  assign unused_bits = ^{apb.PADDR[31:4], apb.PADDR[1:0], apb.PWDATA[31:8]};

  // Transfer decode and FIFO status
  assign access   = apb.PSEL & apb.PENABLE & ~apb.PREADY;
  assign reg_sel  = apb.PADDR[3:2];
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign tx_idle  = tx_empty && (tx_state == T_IDLE);

  // Push/pop qualification; a pop in the same cycle frees the slot a full FIFO needs
  assign tx_pop   = (tx_state == T_IDLE) && !tx_empty && !tx_busy;
  assign tx_push  = access & apb.PWRITE & (reg_sel == A_UWD) & (~tx_full | tx_pop);
  assign rx_pop   = access & ~apb.PWRITE & (reg_sel == A_URD) & ~rx_empty;
  assign rx_push  = rx_done & (~rx_full | rx_pop);
  assign rx_drop  = rx_done & rx_full & ~rx_pop;
  assign ov_clear = access & apb.PWRITE & (reg_sel == A_UCR) & apb.PWDATA[0];

  assign usr = {28'd0, rx_overrun, tx_idle, ~tx_full, ~rx_empty};

  // Read mux for the register selected by PADDR[3:2]
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      A_USR:   rd_val = usr;
      A_URD:   rd_val = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp[AW-1:0]]};
      default: rd_val = '0;
    endcase
  end

  // APB response: single-cycle PREADY pulse, PRDATA captured on the access edge
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      apb.PREADY <= 1'b0;
      apb.PRDATA <= '0;
    end else if (access) begin
      apb.PREADY <= 1'b1;
      apb.PRDATA <= apb.PWRITE ? 32'd0 : rd_val;
    end else begin
      apb.PREADY <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= apb.PWDATA[7:0];
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_data;
  end

  // FIFO pointers and sticky overrun; a new overrun beats a same-cycle clear
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_wp      <= '0;
      tx_rp      <= '0;
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
      if (rx_drop)       rx_overrun <= 1'b1;
      else if (ov_clear) rx_overrun <= 1'b0;
    end
  end

  // TX launcher: pop a byte, pulse tx_start once, then wait for the core to finish
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_state <= T_IDLE;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          tx_start <= 1'b0;
          if (tx_pop) begin
            tx_data  <= tx_mem[tx_rp[AW-1:0]];
            tx_state <= T_START;
          end
        end
        T_START: begin
          tx_start <= 1'b1;
          tx_state <= T_WAIT;
        end
        T_WAIT: begin
          tx_start <= 1'b0;
          if (tx_done) tx_state <= T_IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          tx_state <= T_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_periph.sv
// Bench for apb_uart_periph: directed scenarios plus random register traffic,
// checked against queue-based FIFO models and a simple UART TX core model.
module tb_apb_uart_periph;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] A_USR = 32'h1000_4000;
  localparam logic [31:0] A_UWD = 32'h1000_4004;
  localparam logic [31:0] A_URD = 32'h1000_4008;
  localparam logic [31:0] A_UCR = 32'h1000_400C;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       hold_busy;
  logic       core_busy;

  apb_uart_periph_if bus ();

  apb_uart_periph #(.FIFO_DEPTH(DEPTH)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .apb      (bus),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .rx_data  (rx_data),
    .rx_done  (rx_done)
  );

  assign tx_busy = hold_busy | core_busy;

  initial forever #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Reference model state
  logic [7:0] m_tx [$];
  logic [7:0] m_rx [$];
  logic       m_ov;
  int         busy_len;
  int         tx_launches;
  int         start_cyc;
  int         access_cyc;
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_usr();
    return {28'd0, m_ov, m_tx.size() == 0, m_tx.size() < DEPTH, m_rx.size() != 0};
  endfunction

  // UART TX core model: accepts a byte on tx_start, busy for busy_len cycles, then pulses tx_done
  initial begin
    int   cnt;
    logic prev_start;
    logic [7:0] launched;
    logic [7:0] exp_b;
    core_busy  = 1'b0;
    tx_done    = 1'b0;
    prev_start = 1'b0;
    cnt        = 0;
    launched   = '0;
    forever begin
      @(negedge PCLK);
      tx_done = 1'b0;
      if (PRESET === 1'b1) begin
        core_busy  = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (tx_start === 1'b1) begin
          check("tx_start_single_cycle", 32'(prev_start), 32'd0);
          check("tx_start_with_fifo_data", 32'(m_tx.size() != 0), 32'd1);
          if (m_tx.size() != 0) begin
            exp_b = m_tx.pop_front();
            check("tx_data_order", 32'(tx_data), 32'(exp_b));
          end
          tx_launches++;
          start_cyc = cyc;
          launched  = tx_data;
          core_busy = 1'b1;
          cnt       = busy_len;
        end else if (core_busy) begin
          if (cnt > 0) cnt--;
          else begin
            core_busy = 1'b0;
            tx_done   = 1'b1;
            check("tx_data_stable", 32'(tx_data), 32'(launched));
          end
        end
        prev_start = tx_start;
      end
    end
  end

  // One APB transfer; optionally lands an rx_done pulse on the access edge
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic inj, input logic [7:0] inj_byte, output logic [31:0] rdata);
    int waits;
    @(negedge PCLK);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    if (inj) begin
      rx_done = 1'b1;
      rx_data = inj_byte;
    end
    waits = 0;
    do begin
      @(posedge PCLK);
      #1;
      waits++;
    end while (bus.PREADY !== 1'b1 && waits < 8);
    check("pready_one_wait_state", 32'(waits), 32'd1);
    rdata      = bus.PRDATA;
    access_cyc = cyc;
    @(negedge PCLK);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    rx_done     = 1'b0;
  endtask

  task automatic uwd_write(input logic [7:0] b);
    logic [31:0] r;
    if (m_tx.size() < DEPTH) m_tx.push_back(b);
    apb_xfer(1'b1, A_UWD, {$urandom_range(0, 255), 16'h0, b}, 1'b0, 8'h00, r);
  endtask

  task automatic usr_read(input string tag);
    logic [31:0] e;
    logic [31:0] r;
    e = exp_usr();
    apb_xfer(1'b0, A_USR, 32'h0, 1'b0, 8'h00, r);
    check(tag, r, e);
  endtask

  task automatic urd_read(input string tag);
    logic [31:0] e;
    logic [31:0] r;
    e = (m_rx.size() != 0) ? {24'd0, m_rx.pop_front()} : 32'd0;
    apb_xfer(1'b0, A_URD, 32'h0, 1'b0, 8'h00, r);
    check(tag, r, e);
  endtask

  task automatic ucr_write(input logic [31:0] d);
    logic [31:0] r;
    if (d[0]) m_ov = 1'b0;
    apb_xfer(1'b1, A_UCR, d, 1'b0, 8'h00, r);
  endtask

  task automatic rx_push(input logic [7:0] b);
    if (m_rx.size() < DEPTH) m_rx.push_back(b);
    else m_ov = 1'b1;
    @(negedge PCLK);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge PCLK);
    rx_done = 1'b0;
  endtask

  task automatic drain_tx();
    int n;
    n = 0;
    while ((m_tx.size() != 0 || core_busy || tx_done) && n < 500) begin
      @(negedge PCLK);
      n++;
    end
    check("tx_drain_in_time", 32'(n < 500), 32'd1);
    repeat (3) @(negedge PCLK);
  endtask

  initial begin
    int n0;
    int n;
    logic [7:0] b;
    logic [31:0] d;

    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int n;
    logic [7:0] b;
    logic [31:0] d;
    int op;

    PRESET      = 1'b1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    rx_done     = 1'b0;
    rx_data     = '0;
    hold_busy   = 1'b0;
    m_ov        = 1'b0;
    busy_len    = 10;
    tx_launches = 0;
    start_cyc   = -1;
    access_cyc  = 0;

    // Reset values
    #1;
    check("reset_prdata",   bus.PRDATA, 32'd0);
    check("reset_pready",   32'(bus.PREADY), 32'd0);
    check("reset_tx_data",  32'(tx_data), 32'd0);
    check("reset_tx_start", 32'(tx_start), 32'd0);
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    usr_read("usr_after_reset");

    // 1: single byte, launch latency and final status
    start_cyc = -1;
    uwd_write(8'h41);
    @(posedge PCLK);
    #1;
    check("pready_drops_after_pulse", 32'(bus.PREADY), 32'd0);
    drain_tx();
    check("tx_start_latency", 32'(start_cyc - access_cyc), 32'd2);
    usr_read("usr_after_tx");

    // 2: overfill TX while core is busy
    hold_busy = 1'b1;
    n0 = tx_launches;
    for (int i = 0; i < 5; i++) uwd_write(8'h11 + 8'(i));
    usr_read("usr_tx_full");
    hold_busy = 1'b0;
    drain_tx();
    check("tx_full_drop_count", 32'(tx_launches - n0), 32'd4);
    usr_read("usr_tx_drained");

    // 2b: random partial fill
    busy_len  = 3;
    hold_busy = 1'b1;
    n0 = tx_launches;
    n  = int'($urandom_range(1, 3));
    for (int i = 0; i < n; i++) uwd_write(8'($urandom));
    usr_read("usr_tx_partial");
    hold_busy = 1'b0;
    drain_tx();
    check("tx_partial_count", 32'(tx_launches - n0), 32'(n));

    // 3: two received bytes, then an empty read
    rx_push(8'hA5);
    rx_push(8'h5A);
    usr_read("usr_rx_two");
    urd_read("urd_first");
    urd_read("urd_second");
    urd_read("urd_empty");
    usr_read("usr_rx_empty");

    // 4: overrun and clear
    for (int i = 1; i <= 5; i++) rx_push(8'(i));
    usr_read("usr_overrun");
    for (int i = 0; i < 4; i++) urd_read("urd_overrun_data");
    ucr_write(32'h1);
    usr_read("usr_overrun_cleared");

    // 5: RX full, push on the pop edge, several times to wrap pointers
    for (int i = 0; i < DEPTH; i++) rx_push(8'($urandom));
    for (int i = 0; i < 6; i++) begin
      logic [31:0] e;
      b = 8'($urandom);
      e = {24'd0, m_rx.pop_front()};
      m_rx.push_back(b);
      apb_xfer(1'b0, A_URD, 32'h0, 1'b1, b, rd);
      check("urd_pop_push", rd, e);
    end
    usr_read("usr_full_no_overrun");
    for (int i = 0; i < DEPTH; i++) urd_read("urd_wrap_order");

    // Overrun set wins over a same-cycle clear
    for (int i = 0; i < DEPTH; i++) rx_push(8'($urandom));
    m_ov = 1'b0;
    m_ov = 1'b1;
    apb_xfer(1'b1, A_UCR, 32'h1, 1'b1, 8'hEE, rd);
    usr_read("usr_set_beats_clear");
    while (m_rx.size() != 0) urd_read("urd_after_race");
    ucr_write(32'h1);

    // Random register traffic
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0: rx_push(8'($urandom));
        1: urd_read("rand_urd");
        2: usr_read("rand_usr");
        3: ucr_write($urandom);
        4: begin
          d = $urandom;
          apb_xfer(1'b1, ($urandom_range(0, 1) != 0) ? A_USR : A_URD, d, 1'b0, 8'h00, rd);
          check("rand_write_prdata_zero", rd, 32'd0);
        end
        default: begin
          apb_xfer(1'b0, ($urandom_range(0, 1) != 0) ? A_UWD : A_UCR, 32'h0, 1'b0, 8'h00, rd);
          check("rand_wo_read_zero", rd, 32'd0);
        end
      endcase
    end
    while (m_rx.size() != 0) urd_read("urd_flush");
    ucr_write(32'h1);

    // 6: reset during T_WAIT with FIFOs partly full
    busy_len  = 40;
    hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) uwd_write(8'($urandom));
    rx_push(8'($urandom));
    rx_push(8'($urandom));
    usr_read("usr_before_reset");
    hold_busy = 1'b0;
    n = 0;
    while (!core_busy && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    check("core_started_before_reset", 32'(core_busy), 32'd1);
    repeat (3) @(negedge PCLK);
    n0 = tx_launches;
    #3;
    PRESET = 1'b1;
    #1;
    check("midrun_reset_prdata",   bus.PRDATA, 32'd0);
    check("midrun_reset_pready",   32'(bus.PREADY), 32'd0);
    check("midrun_reset_tx_data",  32'(tx_data), 32'd0);
    check("midrun_reset_tx_start", 32'(tx_start), 32'd0);
    m_tx.delete();
    m_rx.delete();
    m_ov = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    repeat (60) @(negedge PCLK);
    check("no_tx_after_reset", 32'(tx_launches - n0), 32'd0);
    usr_read("usr_after_midrun_reset");
    urd_read("urd_after_midrun_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
